unpack_rq0_par: RTL and testbench

//  Parametrised Rq0 polynomial unpacker; successor to the fixed two-lane unpacker.

---
 rtl/unpack_pkg.sv | 21 ++
 rtl/unpack_lane_sum.sv | 22 ++
 rtl/unpack_rq0_par.sv | 156 +++++++++++++++
 tb/tb_unpack_rq0_par.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unpack_pkg.sv
// Shared definitions for the Rq0 polynomial unpacker.
//   state_t    : unpacker FSM states
//   COEF_W_DEF : default coefficient width
//   neg_mod    : two's-complement negation; callers truncate to their width,
//                which gives the additive inverse mod 2^COEF_W (0 maps to 0)
package unpack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int COEF_W_DEF = 13;

  function automatic logic [31:0] neg_mod(input logic [31:0] x);
    return (~x) + 32'd1;
  endfunction

endpackage

// File: rtl/unpack_lane_sum.sv
// Combinational adder over all lanes of one beat, result mod 2^COEF_W.
// Ports:
//   i_lanes : LANES packed coefficients, lane i at bits [i*COEF_W +: COEF_W]
//   o_sum   : sum of all lanes, mod 2^COEF_W
module unpack_lane_sum
  import unpack_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int LANES  = 2
) (
  input  logic [LANES*COEF_W-1:0] i_lanes,
  output logic [COEF_W-1:0]       o_sum
);

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      o_sum = o_sum + i_lanes[i*COEF_W +: COEF_W];
    end
  end

endmodule

// File: rtl/unpack_rq0_par.sv
// Parametrised Rq0 polynomial unpacker.
// Takes N-1 coefficients, LANES per beat, over a valid/ready stream, stores
// them into the flat register h_mem and derives coefficient N-1 as the
// negated running sum (all coefficients of an Rq0 element sum to zero).
// Ports:
//   clk, ovr_rst : clock (rising edge), asynchronous active-high reset
//   start        : begin a new polynomial (honoured in IDLE/DONE only)
//   in_valid     : in_coef holds a beat
//   in_ready     : block accepts a beat this cycle (state LOAD)
//   in_coef      : LANES coefficients, lane i = coef beat*LANES+i
//   busy         : state is LOAD or FINAL
//   done         : h_mem complete; held until next start
//   h_mem        : coef k at bits [k*COEF_W +: COEF_W]
//   coef_cnt     : coefficients written so far
// Optional feature (macro UNPACK_CHECK_EN):
//   chk_coef     : expected coef N-1, sampled with the last beat
//   chk_err      : set in FINAL when chk_coef differs from the derived coef
module unpack_rq0_par
  import unpack_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int N      = 701,
  parameter int LANES  = 2
) (
  input  logic                    clk,
  input  logic                    ovr_rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*COEF_W-1:0] in_coef,
  output logic                    busy,
  output logic                    done,
  output logic [N*COEF_W-1:0]     h_mem,
  output logic [$clog2(N+1)-1:0]  coef_cnt
`ifdef UNPACK_CHECK_EN
  ,
  input  logic [COEF_W-1:0]       chk_coef,
  output logic                    chk_err
`endif
);

  localparam int BEATS  = (N - 1) / LANES;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int CNT_W  = $clog2(N + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if ((N - 1) % LANES != 0) begin : g_lanes_bad
    $error("unpack_rq0_par: N-1 must be a multiple of LANES");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N*COEF_W-1:0] r_h_mem;
  logic [COEF_W-1:0]   r_acc;
  logic [BEAT_W-1:0]   r_beat;
  logic [CNT_W-1:0]    r_coef_cnt;
  logic                r_done;

  logic                w_xfer;
  logic                w_last;
  logic                w_start_ok;
  logic [COEF_W-1:0]   w_lane_sum;
  logic [COEF_W-1:0]   w_neg;

  unpack_lane_sum #(
    .COEF_W(COEF_W),
    .LANES (LANES)
  ) u_lane_sum (
    .i_lanes(in_coef),
    .o_sum  (w_lane_sum)
  );

  assign w_xfer     = in_valid && (r_state == LOAD);
  assign w_last     = (r_beat == LAST_BEAT);
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_neg      = COEF_W'(neg_mod(32'(r_acc)));

  always_ff @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE:  if (start) w_state_nxt = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_xfer && w_last) w_state_nxt = FINAL;
      end
      FINAL: begin
        busy        = 1'b1;
        w_state_nxt = DONE;
      end
      DONE:  if (start) w_state_nxt = LOAD;
      default: w_state_nxt = IDLE;
    endcase
  end

  // start, beat transfer and FINAL are mutually exclusive by state
  always_ff @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) begin
      r_h_mem    <= '0;
      r_acc      <= '0;
      r_beat     <= '0;
      r_coef_cnt <= '0;
      r_done     <= 1'b0;
    end else if (w_start_ok) begin
      r_h_mem    <= '0;
      r_acc      <= '0;
      r_beat     <= '0;
      r_coef_cnt <= '0;
      r_done     <= 1'b0;
    end else if (w_xfer) begin
      // indexed write keeps the datapath independent of LANES
      for (int i = 0; i < LANES; i++) begin
        r_h_mem[(int'(r_beat) * LANES + i) * COEF_W +: COEF_W] <= in_coef[i*COEF_W +: COEF_W];
      end
      r_acc      <= r_acc + w_lane_sum;
      r_coef_cnt <= r_coef_cnt + CNT_W'(LANES);
      r_beat     <= r_beat + BEAT_W'(1);
    end else if (r_state == FINAL) begin
      r_h_mem[(N-1)*COEF_W +: COEF_W] <= w_neg;
      r_coef_cnt <= CNT_W'(N);
      r_done     <= 1'b1;
    end
  end

  assign h_mem    = r_h_mem;
  assign coef_cnt = r_coef_cnt;
  assign done     = r_done;

`ifdef UNPACK_CHECK_EN
  logic [COEF_W-1:0] r_chk_coef;
  logic              r_chk_err;

  always_ff @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) begin
      r_chk_coef <= '0;
      r_chk_err  <= 1'b0;
    end else if (w_start_ok) begin
      r_chk_err  <= 1'b0;
    end else if (w_xfer && w_last) begin
      r_chk_coef <= chk_coef;
    end else if (r_state == FINAL) begin
      r_chk_err  <= (r_chk_coef != w_neg);
    end
  end

  assign chk_err = r_chk_err;
`endif

endmodule

// File: tb/tb_unpack_rq0_par.sv
// Bench for unpack_rq0_par: a small instance (N=5) for directed vectors and
// a default instance (N=701) for a long stream and the mid-LOAD reset.
// Finished polynomials are checked by a monitor against a queue of expected
// h_mem images pushed by the stimulus.
module tb_unpack_rq0_par;

  localparam int SW = 5 * 13;
  localparam int BW = 701 * 13;

  logic clk;
  logic ovr_rst;

  logic          s_start, s_valid, s_ready, s_busy, s_done;
  logic [25:0]   s_coef;
  logic [SW-1:0] s_h;
  logic [2:0]    s_cnt;

  logic          b_start, b_valid, b_ready, b_busy, b_done;
  logic [25:0]   b_coef;
  logic [BW-1:0] b_h;
  logic [9:0]    b_cnt;

`ifdef UNPACK_CHECK_EN
  logic [12:0]   s_chk;
  logic          s_chk_err;
  logic          b_chk_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] s_exp_q[$];
  logic [BW-1:0] b_exp_q[$];

  unpack_rq0_par #(.COEF_W(13), .N(5), .LANES(2)) u_small (
    .clk     (clk),
    .ovr_rst (ovr_rst),
    .start   (s_start),
    .in_valid(s_valid),
    .in_ready(s_ready),
    .in_coef (s_coef),
    .busy    (s_busy),
    .done    (s_done),
    .h_mem   (s_h),
    .coef_cnt(s_cnt)
`ifdef UNPACK_CHECK_EN
    ,
    .chk_coef(s_chk),
    .chk_err (s_chk_err)
`endif
  );

  unpack_rq0_par u_big (
    .clk     (clk),
    .ovr_rst (ovr_rst),
    .start   (b_start),
    .in_valid(b_valid),
    .in_ready(b_ready),
    .in_coef (b_coef),
    .busy    (b_busy),
    .done    (b_done),
    .h_mem   (b_h),
    .coef_cnt(b_cnt)
`ifdef UNPACK_CHECK_EN
    ,
    .chk_coef(13'd0),
    .chk_err (b_chk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic s_done_q = 1'b0;
  logic b_done_q = 1'b0;

  always @(negedge clk) begin
    if (s_done && !s_done_q) begin
      checks++;
      if (s_exp_q.size() == 0) begin
        errors++;
        $display("FAIL s_unexpected_done: got done=1 expected no completion");
      end else begin
        logic [SW-1:0] e;
        e = s_exp_q.pop_front();
        if (s_h !== e) begin
          errors++;
          $display("FAIL s_h_mem: got %0h expected %0h", s_h, e);
        end
        checks++;
        if (s_cnt !== 3'd5) begin
          errors++;
          $display("FAIL s_coef_cnt_done: got %0d expected 5", s_cnt);
        end
      end
    end
    s_done_q = s_done;

    if (b_done && !b_done_q) begin
      checks++;
      if (b_exp_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_done: got done=1 expected no completion");
      end else begin
        logic [BW-1:0] e;
        int bad;
        e = b_exp_q.pop_front();
        bad = -1;
        for (int k = 700; k >= 0; k--) if (b_h[k*13 +: 13] !== e[k*13 +: 13]) bad = k;
        if (bad >= 0) begin
          errors++;
          $display("FAIL b_h_mem coef %0d: got %0d expected %0d",
                   bad, b_h[bad*13 +: 13], e[bad*13 +: 13]);
        end
        checks++;
        if (b_cnt !== 10'd701) begin
          errors++;
          $display("FAIL b_coef_cnt_done: got %0d expected 701", b_cnt);
        end
      end
    end
    b_done_q = b_done;
  end

  // ---------------- small-instance stimulus ----------------
  task automatic s_go();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask

  task automatic s_beat(input logic [12:0] a, input logic [12:0] b);
    int n;
    s_valid = 1'b1;
    s_coef  = {b, a};
    n = 0;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    if (!s_ready) chk("s_ready_timeout", s_ready, 1);
    tick();
    s_valid = 1'b0;
  endtask

  // ---------------- big-instance stimulus ----------------
  // abort_at < 0: full polynomial; otherwise async reset while that beat is offered
  task automatic b_poly(input int abort_at);
    logic [BW-1:0] exp;
    logic [12:0]   c0, c1;
    logic [9:0]    prev;
    int            sum;
    exp = '0;
    sum = 0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b_ready_after_start", b_ready, 1);
    for (int bt = 0; bt < 350; bt++) begin
      c0 = 13'($urandom);
      c1 = 13'($urandom);
      while ($urandom_range(0, 3) == 0) begin
        b_valid = 1'b0;
        prev = b_cnt;
        tick();
        chk("b_cnt_hold_bubble", b_cnt, prev);
      end
      b_valid = 1'b1;
      b_coef  = {c1, c0};
      if (bt == abort_at) begin
        #3 ovr_rst = 1'b1;
        #2;
        chk("b_rst_h_zero", (b_h == '0), 1);
        chk("b_rst_cnt", b_cnt, 0);
        chk("b_rst_done", b_done, 0);
        chk("b_rst_busy", b_busy, 0);
        chk("b_rst_ready", b_ready, 0);
        ovr_rst = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("b_idle_after_rst", b_ready, 0);
        return;
      end
      prev = b_cnt;
      tick();
      b_valid = 1'b0;
      chk("b_cnt_step", b_cnt, 10'(prev + 10'd2));
      exp[(2*bt)*13 +: 13]   = c0;
      exp[(2*bt+1)*13 +: 13] = c1;
      sum = sum + int'(c0) + int'(c1);
    end
    exp[700*13 +: 13] = 13'((8192 - (sum % 8192)) % 8192);
    b_exp_q.push_back(exp);
    chk("b_ready_after_last", b_ready, 0);
    chk("b_done_not_yet", b_done, 0);
    tick();
    chk("b_done_set", b_done, 1);
    repeat (3) tick();
    chk("b_done_held", b_done, 1);
    chk("b_h_stable", (b_h == exp), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    ovr_rst = 1'b1;
    s_start = 1'b0; s_valid = 1'b0; s_coef = '0;
    b_start = 1'b0; b_valid = 1'b0; b_coef = '0;
`ifdef UNPACK_CHECK_EN
    s_chk = '0;
`endif
    repeat (3) @(posedge clk);
    #1 ovr_rst = 1'b0;

    // reset state
    chk("rst_s_h", s_h, 0);
    chk("rst_s_cnt", s_cnt, 0);
    chk("rst_s_done", s_done, 0);
    chk("rst_s_busy", s_busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_b_h_zero", (b_h == '0), 1);

    // basic vector and latency
    s_go();
    chk("t1_ready_load", s_ready, 1);
    s_exp_q.push_back({13'd8182, 13'd4, 13'd3, 13'd2, 13'd1});
    s_beat(13'd1, 13'd2);
    chk("t1_cnt_beat1", s_cnt, 2);
    s_beat(13'd3, 13'd4);
    chk("t1_done_after_last", s_done, 0);
    chk("t1_ready_final", s_ready, 0);
    chk("t1_busy_final", s_busy, 1);
    chk("t1_cnt_final", s_cnt, 4);
    tick();
    chk("t1_done", s_done, 1);
    chk("t1_busy_done", s_busy, 0);
    tick();
    chk("t1_done_hold", s_done, 1);

    // start in DONE clears; all-zero polynomial
    s_go();
    chk("t2_h_cleared", s_h, 0);
    chk("t2_done_cleared", s_done, 0);
    chk("t2_cnt_cleared", s_cnt, 0);
    s_exp_q.push_back('0);
    s_beat(13'd0, 13'd0);
    s_beat(13'd0, 13'd0);
    repeat (2) tick();

    // wrap: 4096+4096 = 8192 = 0 mod 2^13
    s_go();
    s_exp_q.push_back({13'd0, 13'd0, 13'd0, 13'd4096, 13'd4096});
    s_beat(13'd4096, 13'd4096);
    s_beat(13'd0, 13'd0);
    repeat (2) tick();

    // start during LOAD ignored, with a bubble
    s_go();
    s_exp_q.push_back({13'd8166, 13'd8, 13'd7, 13'd6, 13'd5});
    s_beat(13'd5, 13'd6);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("t5_start_in_load_cnt", s_cnt, 2);
    chk("t5_start_in_load_ready", s_ready, 1);
    s_beat(13'd7, 13'd8);
    repeat (2) tick();

    // start and in_valid together in IDLE: no beat taken
    ovr_rst = 1'b1;
    tick();
    ovr_rst = 1'b0;
    s_start = 1'b1;
    s_valid = 1'b1;
    s_coef  = {13'd9, 13'd9};
    tick();
    s_start = 1'b0;
    s_valid = 1'b0;
    chk("t5_idle_start_valid_cnt", s_cnt, 0);
    chk("t5_idle_start_valid_h", s_h, 0);
    chk("t5_idle_start_valid_ready", s_ready, 1);
    s_exp_q.push_back({13'd8188, 13'd1, 13'd1, 13'd1, 13'd1});
    s_beat(13'd1, 13'd1);
    s_beat(13'd1, 13'd1);
    repeat (2) tick();

`ifdef UNPACK_CHECK_EN
    s_go();
    s_exp_q.push_back({13'd8182, 13'd4, 13'd3, 13'd2, 13'd1});
    s_beat(13'd1, 13'd2);
    s_chk = 13'd8182;
    s_beat(13'd3, 13'd4);
    tick();
    chk("t6_chk_ok", s_chk_err, 0);
    s_go();
    s_exp_q.push_back({13'd8182, 13'd4, 13'd3, 13'd2, 13'd1});
    s_beat(13'd1, 13'd2);
    s_chk = 13'd8181;
    s_beat(13'd3, 13'd4);
    tick();
    chk("t6_chk_err", s_chk_err, 1);
    repeat (3) tick();
    chk("t6_chk_err_held", s_chk_err, 1);
    s_go();
    chk("t6_chk_err_cleared", s_chk_err, 0);
`endif

    // long random stream with bubbles on the default instance
    b_poly(-1);
    // asynchronous reset mid-LOAD, then a full unpack
    b_poly(100);
    b_poly(-1);

    tick();
    chk("s_queue_empty", s_exp_q.size(), 0);
    chk("b_queue_empty", b_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: got no completion expected end of sequence");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
